dmem_pipe: RTL and testbench
============================

DMEM_PIPE -- requirements
Module: dmem_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 16: data word width in bits; multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 8: word-address width.
REQ-003 SHALL have parameter DEPTH, default 256: number of words; must satisfy DEPTH <= 2**ADDR_W.
REQ-004 SHALL have parameter RD_LAT, default 1: cycles from accept to response, legal range 1..4.
REQ-005 SHALL have port clk, input, 1: single clock; all state is updated on the rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port req_valid, input, 1: request present.
REQ-008 SHALL have port req_ready, output, 1: block can accept a request.
REQ-009 SHALL have port req_we, input, 1: 1 = write, 0 = read.
REQ-010 SHALL have port req_addr, input, ADDR_W: word address.
REQ-011 SHALL have port req_wdata, input, DATA_W: write data.
REQ-012 SHALL have port req_be, input, DATA_W/8: byte enables for writes.
REQ-013 SHALL have port rsp_valid, output, 1: response present.
REQ-014 SHALL have port rsp_ready, input, 1: consumer accepts the response.
REQ-015 SHALL have port rsp_rdata, output, DATA_W: read data; 0 for writes and errors.
REQ-016 SHALL have port rsp_err, output, 1: address out of range, or parity error when parity is compiled in.

Function
REQ-017 SHALL accept a request only on a cycle where req_valid and req_ready are both 1; only one request is outstanding at a time.
REQ-018 SHALL implement the FSM IDLE -> WAIT -> RESP -> IDLE:
  - req_ready = 1 only in IDLE.
  - Accept moves IDLE to WAIT and loads a latency counter with RD_LAT-1.
  - WAIT moves to RESP when the counter reaches 0; with RD_LAT = 1, WAIT lasts 1 cycle.
REQ-019 SHALL assert rsp_valid exactly RD_LAT+1 cycles after the accept edge, and hold it together with rsp_rdata and rsp_err stable until rsp_ready = 1.
REQ-020 SHALL, on the edge where rsp_valid and rsp_ready are both 1, return the FSM to IDLE, so the next accept can happen no earlier than the following edge.
REQ-021 SHALL commit an in-range write on its accept edge, updating only bytes whose req_be bit is 1; the write response has rsp_rdata = 0 and rsp_err = 0.
REQ-022 SHALL return, for an in-range read, the stored word as of the accept edge.
REQ-023 SHALL, for req_addr >= DEPTH, leave memory unchanged and respond with rsp_err = 1 and rsp_rdata = 0 for both reads and writes.
REQ-024 SHALL treat a write with req_be = 0 as a no-op that still produces a normal response.
REQ-025 SHALL initialise word k to k truncated to DATA_W bits at time zero; memory contents are not reset.

Reset
REQ-026 SHALL, while rst_n = 0, force FSM = IDLE, counter = 0, req_ready = 1, rsp_valid = 0, rsp_rdata = 0 and rsp_err = 0.
REQ-027 SHALL, on reset mid-transaction, drop any pending response; a write already accepted remains committed.

Configuration
REQ-028 SHALL, with DMEM_PARITY_EN defined:
  - store one even-parity bit per byte on every write;
  - check parity on every read and set rsp_err = 1 on mismatch while still returning the stored data;
  - add input port err_inject (1 bit): when 1 on a write's accept edge, the stored parity of every enabled byte is inverted.
REQ-029 SHALL, without DMEM_PARITY_EN, have no parity storage and no err_inject port; rsp_err then reflects only the address range.

Structure
REQ-030 SHALL place the FSM state enum, the RD_LAT bounds and the parity function in shared package dmem_pkg.
REQ-031 SHALL instantiate one sub-module dmem_array holding the storage, a byte-enabled write port and a registered read port; dmem_pipe holds the handshake FSM and latency counter.

Verification
REQ-032 SHALL cover: with RD_LAT = 1, read addr 0x05 -> rsp_valid 2 cycles after accept, rsp_rdata = 0x0005, rsp_err = 0.
REQ-033 SHALL cover: write addr 0x10, wdata 0xABCD, be = 2'b01, then read addr 0x10 -> 0x00CD.
REQ-034 SHALL cover: with DEPTH = 200, write addr 0xC8 -> rsp_err = 1; then read addr 0xC8 -> rsp_err = 1, rsp_rdata = 0.
REQ-035 SHALL cover: with RD_LAT = 4 and rsp_ready held 0 for 5 cycles -> rsp_valid stays high with stable data and req_ready = 0 throughout.
REQ-036 SHALL cover: rst_n asserted in WAIT after a write of 0x1234 to addr 0x20 -> no response appears, and a later read of 0x20 returns 0x1234.
REQ-037 SHALL cover, with DMEM_PARITY_EN defined: write with err_inject = 1 to addr 0x30, then read addr 0x30 -> rsp_err = 1 and the written data is returned.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the dmem_pipe slice: handshake FSM states,
// read-latency bounds and the per-byte parity helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 4;
    // Wide enough to hold RD_LAT_MAX-1.
    localparam int unsigned LAT_CNT_W  = 2;

    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for dmem_pipe: byte-enabled write port and registered read port.
// Word k powers up holding k. With DMEM_PARITY_EN defined, one even-parity bit
// per byte is stored and checked on read; err_inject flips the stored parity.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
`ifdef DMEM_PARITY_EN
    input  logic                err_inject,
`endif
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_err
);

    localparam int unsigned NB = DATA_W / 8;

    logic [DATA_W-1:0] words [DEPTH];
`ifdef DMEM_PARITY_EN
    logic [NB-1:0]     pars  [DEPTH];

    function automatic logic [NB-1:0] word_parity(input logic [DATA_W-1:0] w);
        logic [NB-1:0] p;
        p = '0;
        for (int unsigned b = 0; b < NB; b++) p[b] = byte_parity(w[8*b +: 8]);
        return p;
    endfunction
`endif

    // One register per word so each can carry its own power-up value
    // without a reset (contents survive rst_n).
    for (genvar k = 0; k < DEPTH; k++) begin : g_word
        logic [DATA_W-1:0] data = DATA_W'(k);
`ifdef DMEM_PARITY_EN
        logic [NB-1:0]     par  = word_parity(DATA_W'(k));
`endif

        // Byte-enabled write into this word
        always_ff @(posedge clk) begin
            if (wr_en && addr == ADDR_W'(k)) begin
                for (int unsigned b = 0; b < NB; b++) begin
                    if (be[b]) begin
                        data[8*b +: 8] <= wdata[8*b +: 8];
`ifdef DMEM_PARITY_EN
                        par[b] <= byte_parity(wdata[8*b +: 8]) ^ err_inject;
`endif
                    end
                end
            end
        end

        assign words[k] = data;
`ifdef DMEM_PARITY_EN
        assign pars[k]  = par;
`endif
    end

    // Registered read: captures the word as it stood before this edge's update
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= words[addr];
        end
    end

`ifdef DMEM_PARITY_EN
    // Registered parity check alongside the read data
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_err <= |(pars[addr] ^ word_parity(words[addr]));
        end
    end
`else
    assign rd_err = 1'b0;
`endif

endmodule

// File: rtl/dmem_pipe.sv
// Single-outstanding request/response memory with programmable read latency.
// Response appears RD_LAT+1 edges after accept and is held until rsp_ready.
// Optional DMEM_PARITY_EN adds per-byte parity and the err_inject input.
module dmem_pipe
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
`ifdef DMEM_PARITY_EN
    input  logic                err_inject,
`endif
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);

    localparam int unsigned LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                                  (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

    state_t               state, state_nxt;
    logic [LAT_CNT_W-1:0] lat_cnt;
    logic                 accept, in_range, rsp_fire;
    logic                 oob_q, we_q;
    logic [DATA_W-1:0]    arr_rdata;
    logic                 arr_err;

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign in_range  = {1'b0, req_addr} < DEPTH_LIM;
    assign rsp_fire  = rsp_valid && rsp_ready;

    dmem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk        (clk),
        .wr_en      (accept && req_we && in_range),
        .rd_en      (accept && !req_we && in_range),
        .addr       (req_addr),
        .wdata      (req_wdata),
        .be         (req_be),
`ifdef DMEM_PARITY_EN
        .err_inject (err_inject),
`endif
        .rd_data    (arr_rdata),
        .rd_err     (arr_err)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic for the IDLE -> WAIT -> RESP handshake
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)          state_nxt = ST_WAIT;
            ST_WAIT: if (lat_cnt == '0)   state_nxt = ST_RESP;
            ST_RESP: if (rsp_fire)        state_nxt = ST_IDLE;
            default:                      state_nxt = ST_IDLE;
        endcase
    end

    // Latency counter and attributes of the accepted request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_cnt <= '0;
            oob_q   <= 1'b0;
            we_q    <= 1'b0;
        end else if (accept) begin
            lat_cnt <= LAT_CNT_W'(LAT - 1);
            oob_q   <= !in_range;
            we_q    <= req_we;
        end else if (state == ST_WAIT && lat_cnt != '0) begin
            lat_cnt <= lat_cnt - 1'b1;
        end
    end

    // Response register: loaded once on entering RESP, held until consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (state == ST_RESP && !rsp_valid) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= (oob_q || we_q) ? '0 : arr_rdata;
            rsp_err   <= oob_q || (!we_q && arr_err);
        end else if (rsp_fire) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_pipe.sv
// Self-checking bench for dmem_pipe: two instances (RD_LAT 1 and 4, DEPTH 200)
// checked every cycle against a transaction-level memory model.
module tb_dmem_pipe;

    localparam int DEPTH = 200;
    localparam int LAT0  = 1;
    localparam int LAT1  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_n     [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [7:0]  req_addr  [2];
    logic [15:0] req_wdata [2];
    logic [1:0]  req_be    [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [15:0] rsp_rdata [2];
    logic        rsp_err   [2];
`ifdef DMEM_PARITY_EN
    logic        err_inject[2];
`endif

    dmem_pipe #(.DATA_W(16), .ADDR_W(8), .DEPTH(DEPTH), .RD_LAT(LAT0)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
`ifdef DMEM_PARITY_EN
        .err_inject(err_inject[0]),
`endif
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_pipe #(.DATA_W(16), .ADDR_W(8), .DEPTH(DEPTH), .RD_LAT(LAT1)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
`ifdef DMEM_PARITY_EN
        .err_inject(err_inject[1]),
`endif
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    // Reference model: plain word memory plus per-byte "poisoned" flags
    logic [15:0] mem_m [2][256];
    bit          bad_m [2][256][2];

    // Outstanding-response expectation per instance
    bit          exp_active [2];
    int          exp_rise   [2];
    logic [15:0] exp_rd     [2];
    logic        exp_err    [2];
    bit          prev_vexp  [2];

    int n_chk  = 0;
    int n_fail = 0;

    function automatic int lat_of(int i);
        return (i == 0) ? LAT0 : LAT1;
    endfunction

    task automatic check(string name, int i, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got 0x%0h expected 0x%0h", name, i, cyc, act, exp);
        end
    endtask

    // Per-cycle compare, sampled just after each rising edge
    initial begin
        logic v;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (!rst_n[i]) begin
                    check("rst_rsp_valid", i, rsp_valid[i], 0);
                    check("rst_req_ready", i, req_ready[i], 1);
                    check("rst_rsp_rdata", i, rsp_rdata[i], 0);
                    check("rst_rsp_err",   i, rsp_err[i],   0);
                    prev_vexp[i] = 0;
                end else begin
                    if (prev_vexp[i] && rsp_ready[i]) exp_active[i] = 0;
                    v = exp_active[i] && (cyc >= exp_rise[i]);
                    check("rsp_valid", i, rsp_valid[i], v);
                    check("req_ready", i, req_ready[i], !exp_active[i]);
                    if (v) begin
                        check("rsp_rdata", i, rsp_rdata[i], exp_rd[i]);
                        check("rsp_err",   i, rsp_err[i],   exp_err[i]);
                    end
                    prev_vexp[i] = v;
                end
            end
        end
    end

    // One transaction: lit=1 pins the response to literal values;
    // rst_at>=0 asserts reset that many cycles after accept and drops the response.
    task automatic txn(int i, bit we, logic [7:0] addr, logic [15:0] wd, logic [1:0] be,
                       bit inj, int hold, int rst_at, bit lit, logic [15:0] lrd, bit lerr);
        int  n;
        int  rise;
        bit  oob;
        @(negedge clk);
        n = 0;
        while (!req_ready[i] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[i]) begin
            check("ready_timeout", i, req_ready[i], 1);
            return;
        end
        oob = (addr >= DEPTH);
        if (oob) begin
            exp_rd[i]  = 16'h0;
            exp_err[i] = 1'b1;
        end else if (we) begin
            exp_rd[i]  = 16'h0;
            exp_err[i] = 1'b0;
            for (int b = 0; b < 2; b++) begin
                if (be[b]) begin
                    mem_m[i][addr][8*b +: 8] = wd[8*b +: 8];
                    bad_m[i][addr][b] = inj;
                end
            end
        end else begin
            exp_rd[i]  = mem_m[i][addr];
`ifdef DMEM_PARITY_EN
            exp_err[i] = bad_m[i][addr][0] | bad_m[i][addr][1];
`else
            exp_err[i] = 1'b0;
`endif
        end
        rise          = cyc + 1 + lat_of(i) + 1;
        exp_rise[i]   = rise;
        exp_active[i] = 1;
        req_valid[i]  = 1'b1;
        req_we[i]     = we;
        req_addr[i]   = addr;
        req_wdata[i]  = wd;
        req_be[i]     = be;
`ifdef DMEM_PARITY_EN
        err_inject[i] = inj;
`endif
        rsp_ready[i]  = 1'b0;
        @(negedge clk);
        req_valid[i]  = 1'b0;
`ifdef DMEM_PARITY_EN
        err_inject[i] = 1'b0;
`endif
        if (rst_at >= 0) begin
            repeat (rst_at) @(negedge clk);
            rst_n[i]      = 1'b0;
            exp_active[i] = 0;
            @(negedge clk);
            check("mid_rst_valid", i, rsp_valid[i], 0);
            check("mid_rst_ready", i, req_ready[i], 1);
            @(negedge clk);
            rst_n[i] = 1'b1;
            repeat (lat_of(i) + 3) @(negedge clk);
            check("no_rsp_after_rst", i, rsp_valid[i], 0);
            return;
        end
        while (cyc < rise - 1) @(negedge clk);
        if (lit) check("pre_rise_valid", i, rsp_valid[i], 0);
        @(negedge clk);
        if (lit) begin
            check("lit_valid", i, rsp_valid[i], 1);
            check("lit_rdata", i, rsp_rdata[i], lrd);
            check("lit_err",   i, rsp_err[i],   lerr);
        end
        repeat (hold) @(negedge clk);
        if (lit && hold > 0) begin
            check("held_valid", i, rsp_valid[i], 1);
            check("held_ready", i, req_ready[i], 0);
            check("held_rdata", i, rsp_rdata[i], lrd);
            check("held_err",   i, rsp_err[i],   lerr);
        end
        rsp_ready[i] = 1'b1;
        @(negedge clk);
        rsp_ready[i] = 1'b0;
    endtask

    task automatic random_txns(int i, int count);
        logic [7:0]  a;
        logic [15:0] d;
        logic [1:0]  be;
        bit          we, inj;
        for (int t = 0; t < count; t++) begin
            a   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(190, 255)) : 8'($urandom_range(0, 15));
            d   = 16'($urandom);
            be  = 2'($urandom_range(0, 3));
            we  = 1'($urandom_range(0, 1));
`ifdef DMEM_PARITY_EN
            inj = ($urandom_range(0, 7) == 0);
`else
            inj = 0;
`endif
            txn(i, we, a, d, be, inj, int'($urandom_range(0, 3)), -1, 0, 16'h0, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 256; k++) begin
                mem_m[i][k] = 16'(k);
                bad_m[i][k][0] = 0;
                bad_m[i][k][1] = 0;
            end
            exp_active[i] = 0;
            exp_rise[i]   = 0;
            exp_rd[i]     = '0;
            exp_err[i]    = 0;
            prev_vexp[i]  = 0;
            rst_n[i]      = 1'b0;
            req_valid[i]  = 1'b0;
            req_we[i]     = 1'b0;
            req_addr[i]   = '0;
            req_wdata[i]  = '0;
            req_be[i]     = '0;
            rsp_ready[i]  = 1'b0;
`ifdef DMEM_PARITY_EN
            err_inject[i] = 1'b0;
`endif
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("reset_ready", i, req_ready[i], 1);
            check("reset_valid", i, rsp_valid[i], 0);
            check("reset_rdata", i, rsp_rdata[i], 0);
            check("reset_err",   i, rsp_err[i],   0);
            rst_n[i] = 1'b1;
        end

        // RD_LAT = 1 instance
        txn(0, 0, 8'h05, 16'h0000, 2'b00, 0, 0, -1, 1, 16'h0005, 0);
        txn(0, 1, 8'h10, 16'hABCD, 2'b01, 0, 0, -1, 1, 16'h0000, 0);
        txn(0, 0, 8'h10, 16'h0000, 2'b00, 0, 0, -1, 1, 16'h00CD, 0);
        txn(0, 1, 8'hC8, 16'h1111, 2'b11, 0, 0, -1, 1, 16'h0000, 1);
        txn(0, 0, 8'hC8, 16'h0000, 2'b00, 0, 0, -1, 1, 16'h0000, 1);
        txn(0, 0, 8'hC7, 16'h0000, 2'b00, 0, 0, -1, 1, 16'h00C7, 0);
        txn(0, 1, 8'h11, 16'hFFFF, 2'b00, 0, 0, -1, 1, 16'h0000, 0);
        txn(0, 0, 8'h11, 16'h0000, 2'b00, 0, 0, -1, 1, 16'h0011, 0);
`ifdef DMEM_PARITY_EN
        txn(0, 1, 8'h30, 16'h5A5A, 2'b11, 1, 0, -1, 1, 16'h0000, 0);
        txn(0, 0, 8'h30, 16'h0000, 2'b00, 0, 0, -1, 1, 16'h5A5A, 1);
        txn(0, 1, 8'h30, 16'h1234, 2'b11, 0, 0, -1, 1, 16'h0000, 0);
        txn(0, 0, 8'h30, 16'h0000, 2'b00, 0, 0, -1, 1, 16'h1234, 0);
`endif
        random_txns(0, 60);

        // RD_LAT = 4 instance
        txn(1, 0, 8'h07, 16'h0000, 2'b00, 0, 5, -1, 1, 16'h0007, 0);
        txn(1, 1, 8'h20, 16'h1234, 2'b11, 0, 0, 1, 0, 16'h0000, 0);
        txn(1, 0, 8'h20, 16'h0000, 2'b00, 0, 0, -1, 1, 16'h1234, 0);
        txn(1, 0, 8'hFF, 16'h0000, 2'b00, 0, 2, -1, 1, 16'h0000, 1);
        random_txns(1, 60);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
